dmem_arbiter: RTL and testbench

- Shares the single byte-addressed data-memory bank between NREQ requesters (requester 0 = core LSU, requester 1 = keypad/peripheral writer).
- Uses a round-robin grant, one transaction in flight at a time.
- Checks alignment, funct code and address range before any bank access; failing requests get an error response and never reach the bank.
- Registers all bank-side control signals and captures read data into a response register.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_arbiter_rr.sv | 31 +++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [2:0] {
    FN_B  = 3'b000,
    FN_H  = 3'b001,
    FN_W  = 3'b010,
    FN_BU = 3'b100,
    FN_HU = 3'b101
  } funct_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Access size in bytes; low two funct bits encode byte/half/word.
  function automatic logic [2:0] funct_size(input logic [2:0] funct);
    case (funct[1:0])
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic funct_legal(input logic [2:0] funct, input logic write);
    case (funct)
      FN_B, FN_H, FN_W: return 1'b1;
      FN_BU, FN_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_any
);

  // Scan from the pointer upward and stop at the first requester found.
  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!gnt_any && req[k]) begin
        gnt_any = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory bank among NREQ requesters.
// Requests are checked before touching the bank; one transaction in flight.
//
// state  | meaning
// IDLE   | arbitrating; ready offered to the round-robin winner
// ACCESS | bank enabled for one cycle; load data captured at its end
// RESP   | one-cycle response pulse to the owner; pointer advances
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DMEM_ADDR = 13,
  parameter int DMEM_LAST = 200,
  parameter int NREQ      = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic [NREQ-1:0]           i_req_write,
  input  logic [NREQ*DMEM_ADDR-1:0] i_req_addr,
  input  logic [NREQ*32-1:0]        i_req_wdata,
  input  logic [NREQ*3-1:0]         i_req_funct,
  output logic [NREQ-1:0]           o_rsp_valid,
  output logic                      o_rsp_err,
  output logic [31:0]               o_rsp_rdata,
  output logic                      o_dmem_en,
  output logic                      o_dmem_we,
  output logic [DMEM_ADDR-1:0]      o_dmem_addr,
  output logic [31:0]               o_dmem_wdata,
  output logic [2:0]                o_dmem_funct,
  input  logic [31:0]               i_dmem_rdata
);

  localparam int IDXW = $clog2(NREQ);
  localparam int EW   = DMEM_ADDR + 2;

  arb_state_e state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] owner;

  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_any;

  logic [DMEM_ADDR-1:0] req_addr  [NREQ];
  logic [31:0]          req_wdata [NREQ];
  logic [2:0]           req_funct [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_addr[g]  = i_req_addr[g*DMEM_ADDR +: DMEM_ADDR];
    assign req_wdata[g] = i_req_wdata[g*32 +: 32];
    assign req_funct[g] = i_req_funct[g*3 +: 3];
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (i_req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  logic [DMEM_ADDR-1:0] win_addr;
  logic [31:0]          win_wdata;
  logic [2:0]           win_funct;
  logic                 win_write;
  logic [EW-1:0]        win_end;
  logic                 win_misaligned;
  logic                 win_bad;
  logic                 handshake;

  assign win_addr  = req_addr[gnt_idx];
  assign win_wdata = req_wdata[gnt_idx];
  assign win_funct = req_funct[gnt_idx];
  assign win_write = i_req_write[gnt_idx];

  // Last byte touched, computed two bits wider so it cannot wrap.
  assign win_end = EW'(win_addr) + EW'(funct_size(win_funct)) - EW'(1);

  assign win_misaligned = ((win_funct[1:0] == 2'b01) && win_addr[0]) ||
                          ((win_funct[1:0] == 2'b10) && (win_addr[1:0] != 2'b00));

  assign win_bad = !funct_legal(win_funct, win_write) || win_misaligned ||
                   (win_end > EW'(DMEM_LAST));

  // Ready is offered only while idle and out of reset.
  assign o_req_ready = (state == IDLE && i_rst_n && gnt_any) ? gnt : '0;
  assign handshake   = |(i_req_valid & o_req_ready);

  // Transaction sequencer with registered bank and response outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      o_rsp_valid  <= '0;
      o_rsp_err    <= 1'b0;
      o_rsp_rdata  <= '0;
      o_dmem_en    <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_funct <= '0;
    end else begin
      o_rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (handshake) begin
            owner <= gnt_idx;
            if (win_bad) begin
              // Rejected request answers immediately without touching the bank.
              o_rsp_valid <= gnt;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
              state       <= RESP;
            end else begin
              o_dmem_en    <= 1'b1;
              o_dmem_we    <= win_write;
              o_dmem_addr  <= win_addr;
              o_dmem_wdata <= win_wdata;
              o_dmem_funct <= win_funct;
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          o_rsp_rdata <= o_dmem_we ? '0 : i_dmem_rdata;
          o_rsp_err   <= 1'b0;
          o_rsp_valid <= NREQ'(1) << owner;
          o_dmem_en   <= 1'b0;
          o_dmem_we   <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          ptr   <= (owner == IDXW'(NREQ - 1)) ? '0 : owner + IDXW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter with a byte-array reference.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW   = 13;
  localparam int LAST = 200;
  localparam int N    = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*32-1:0]   req_wdata;
  logic [N*3-1:0]    req_funct;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic              dmem_en, dmem_we;
  logic [AW-1:0]     dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [2:0]        dmem_funct;
  logic [31:0]       dmem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int ref_ptr;

  logic [7:0] ref_mem  [256];
  logic [7:0] bank_mem [256];
  logic       bank_loaded = 1'b0;

  always #5 i_clk = ~i_clk;

  dmem_arbiter #(.DMEM_ADDR(AW), .DMEM_LAST(LAST), .NREQ(N)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_funct  (req_funct),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_err    (rsp_err),
    .o_rsp_rdata  (rsp_rdata),
    .o_dmem_en    (dmem_en),
    .o_dmem_we    (dmem_we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .o_dmem_funct (dmem_funct),
    .i_dmem_rdata (dmem_rdata)
  );

  // Bank: combinational extended read, byte-lane writes on the clock edge.
  function automatic logic [31:0] bank_read(input logic [AW-1:0] a, input logic [2:0] f);
    logic [31:0] w;
    int b;
    b = int'(a);
    w = {bank_mem[(b+3)&255], bank_mem[(b+2)&255], bank_mem[(b+1)&255], bank_mem[b&255]};
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign dmem_rdata = (dmem_en && !dmem_we) ? bank_read(dmem_addr, dmem_funct) : 'z;

  always @(posedge i_clk) begin
    if (!bank_loaded) begin
      for (int i = 0; i < 256; i++) bank_mem[i] <= ref_mem[i];
      bank_loaded <= 1'b1;
    end else if (dmem_en && dmem_we) begin
      bank_mem[dmem_addr[7:0]] <= dmem_wdata[7:0];
      if (dmem_funct[1:0] != 2'b00) bank_mem[dmem_addr[7:0] + 8'd1] <= dmem_wdata[15:8];
      if (dmem_funct[1:0] == 2'b10) begin
        bank_mem[dmem_addr[7:0] + 8'd2] <= dmem_wdata[23:16];
        bank_mem[dmem_addr[7:0] + 8'd3] <= dmem_wdata[31:24];
      end
    end
  end

  // Reference model: access rules stated with plain arithmetic.
  function automatic int size_of(input logic [2:0] f);
    if (f == FN_H || f == FN_HU) return 2;
    if (f == FN_W) return 4;
    return 1;
  endfunction

  function automatic bit model_err(input bit wr, input int addr, input logic [2:0] f);
    bit legal;
    legal = (f == FN_B) || (f == FN_H) || (f == FN_W) ||
            (!wr && (f == FN_BU || f == FN_HU));
    if (!legal) return 1'b1;
    if (addr % size_of(f) != 0) return 1'b1;
    if (addr + size_of(f) - 1 > LAST) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input int addr, input logic [2:0] f);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < size_of(f); i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
    if (f == FN_B && v >= 32'd128)   v = v - 32'd256;
    if (f == FN_H && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic model_store(input int addr, input logic [31:0] wd, input logic [2:0] f);
    for (int i = 0; i < size_of(f); i++) ref_mem[addr + i] = 8'(wd >> (8 * i));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from requester k; checks grant, bank cycle and response timing.
  task automatic do_txn(input int k, input bit wr, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [2:0] f);
    bit          exp_e;
    logic [31:0] exp_d;
    int          w;
    @(negedge i_clk);
    req_valid[k]            = 1'b1;
    req_write[k]            = wr;
    req_addr[k*AW +: AW]    = addr;
    req_wdata[k*32 +: 32]   = wd;
    req_funct[k*3 +: 3]     = f;
    #1;
    w = 0;
    while (!req_ready[k] && w < 20) begin
      @(negedge i_clk); #1; w++;
    end
    check("grant", 32'(req_ready), 32'(1 << k));
    if (!req_ready[k]) begin
      req_valid[k] = 1'b0;
      return;
    end
    exp_e = model_err(wr, int'(addr), f);
    exp_d = 32'd0;
    if (!exp_e && !wr) exp_d = model_load(int'(addr), f);
    if (!exp_e && wr) model_store(int'(addr), wd, f);
    ref_ptr = (k + 1) % N;
    @(posedge i_clk); #1;
    req_valid[k] = 1'b0;
    @(negedge i_clk);
    if (exp_e) begin
      check("err_rsp_valid", 32'(rsp_valid), 32'(1 << k));
      check("err_flag", 32'(rsp_err), 32'd1);
      check("err_rdata", rsp_rdata, 32'd0);
      check("err_bank_en", 32'(dmem_en), 32'd0);
    end else begin
      check("acc_en", 32'(dmem_en), 32'd1);
      check("acc_we", 32'(dmem_we), 32'(wr));
      check("acc_addr", 32'(dmem_addr), 32'(addr));
      check("acc_rsp_quiet", 32'(rsp_valid), 32'd0);
      if (wr) check("acc_wdata", dmem_wdata, wd);
      @(negedge i_clk);
      check("rsp_valid", 32'(rsp_valid), 32'(1 << k));
      check("rsp_err", 32'(rsp_err), 32'd0);
      check("rsp_rdata", rsp_rdata, exp_d);
      check("rsp_en_low", 32'(dmem_en), 32'd0);
    end
  endtask

  // Both requesters load the same location continuously; grants must alternate.
  task automatic fair_run(input logic [2:0] f, input logic [31:0] exp_d, input int count);
    int w;
    int exp_owner;
    @(negedge i_clk);
    for (int k = 0; k < N; k++) begin
      req_valid[k]          = 1'b1;
      req_write[k]          = 1'b0;
      req_addr[k*AW +: AW]  = AW'(13'h020);
      req_wdata[k*32 +: 32] = 32'd0;
      req_funct[k*3 +: 3]   = f;
    end
    #1;
    for (int t = 0; t < count; t++) begin
      w = 0;
      while (req_ready == '0 && w < 20) begin
        @(negedge i_clk); #1; w++;
      end
      check("fair_no_gap", 32'(w), 32'd0);
      exp_owner = ref_ptr;
      check("fair_grant", 32'(req_ready), 32'(1 << exp_owner));
      if (req_ready == '0) break;
      ref_ptr = (exp_owner + 1) % N;
      @(posedge i_clk);
      @(negedge i_clk);
      check("fair_en", 32'(dmem_en), 32'd1);
      @(negedge i_clk);
      check("fair_rsp_valid", 32'(rsp_valid), 32'(1 << exp_owner));
      check("fair_rdata", rsp_rdata, exp_d);
      @(negedge i_clk); #1;
    end
    req_valid = '0;
  endtask

  initial begin
    logic [2:0]    rf;
    logic [AW-1:0] ra;
    bit            rw;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_funct = '0;
    i_rst_n   = 1'b0;
    ref_ptr   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));

    repeat (3) @(negedge i_clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_en", 32'(dmem_en), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", 32'(dmem_addr), 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_funct", 32'(dmem_funct), 32'd0);
    i_rst_n = 1'b1;

    // Word store then load back.
    do_txn(0, 1'b1, 13'h010, 32'hDEADBEEF, FN_W);
    do_txn(0, 1'b0, 13'h010, 32'd0, FN_W);
    @(negedge i_clk);
    check("rdata_hold", rsp_rdata, 32'hDEADBEEF);
    check("rsp_pulse_once", 32'(rsp_valid), 32'd0);

    // Seed 0x80 at 0x020 from requester 1 so the pointer lands on 0.
    do_txn(1, 1'b1, 13'h020, 32'h00000080, FN_B);
    fair_run(FN_B, 32'hFFFFFF80, 4);
    fair_run(FN_BU, 32'h00000080, 4);

    // Rejected requests.
    do_txn(1, 1'b0, 13'h011, 32'd0, FN_H);
    do_txn(0, 1'b0, 13'h0C6, 32'd0, FN_W);
    do_txn(0, 1'b0, 13'h000, 32'd0, 3'b111);
    do_txn(0, 1'b1, 13'h040, 32'h55, FN_BU);
    do_txn(1, 1'b0, 13'h0C8, 32'd0, FN_H);

    // Accepted accesses at the top of the range.
    do_txn(1, 1'b1, 13'h0C4, 32'hA5C3_0F1E, FN_W);
    do_txn(0, 1'b0, 13'h0C4, 32'd0, FN_W);
    do_txn(1, 1'b0, 13'h0C8, 32'd0, FN_BU);
    do_txn(0, 1'b0, 13'h0C6, 32'd0, FN_HU);

    // Random mix of requesters, kinds, sizes and addresses.
    for (int t = 0; t < 60; t++) begin
      rf = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = AW'($urandom_range(0, 205));
      if ($urandom_range(0, 3) != 0) ra = ra & ~AW'(size_of(rf) - 1);
      do_txn(int'($urandom_range(0, 1)), rw, ra, $urandom, rf);
    end

    // Reset in the middle of a store's bank cycle.
    do_txn(0, 1'b0, 13'h010, 32'd0, FN_B);
    @(negedge i_clk);
    req_valid[0]      = 1'b1;
    req_write[0]      = 1'b1;
    req_addr[0 +: AW] = AW'(13'h030);
    req_wdata[0 +: 32] = 32'h0000_1234;
    req_funct[0 +: 3] = FN_H;
    #1;
    check("rst_mid_grant", 32'(req_ready), 32'd1);
    @(posedge i_clk); #1;
    req_valid = '0;
    #1;
    check("rst_mid_en_before", 32'(dmem_en), 32'd1);
    i_rst_n = 1'b0;
    ref_ptr = 0;
    #1;
    check("rst_mid_en", 32'(dmem_en), 32'd0);
    check("rst_mid_we", 32'(dmem_we), 32'd0);
    check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) begin
      @(negedge i_clk);
      check("rst_hold_rsp", 32'(rsp_valid), 32'd0);
    end
    i_rst_n = 1'b1;

    // After reset requester 0 has priority; a dropped valid records nothing.
    @(negedge i_clk);
    req_valid = 2'b11;
    req_write = 2'b00;
    req_funct = '0;
    req_addr  = '0;
    #1;
    check("post_rst_prio", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(negedge i_clk);
    check("drop_no_access", 32'(dmem_en), 32'd0);
    @(negedge i_clk);
    check("drop_no_rsp", 32'(rsp_valid), 32'd0);
    do_txn(1, 1'b0, 13'h020, 32'd0, FN_BU);

    repeat (2) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
